// File: rtl/x68_vid_pkg.sv
// Shared types for the X68000 video path.
// Line-buffer geometry and fill scheduler state encoding.
package x68_vid_pkg;

  localparam int LRAM_AW = 10;

  typedef enum logic [1:0] {
    FILL_IDLE,
    FILL_REQ,
    FILL_DATA
  } fill_state_t;

endpackage

// File: rtl/lram_fill_ctrl.sv
// Line-buffer fill scheduler: fetches one visible line from VRAM in
// fixed bursts and writes it into the idle half of the line RAM.
module lram_fill_ctrl
  import x68_vid_pkg::*;
#(
  parameter int BURST = 8,
  parameter int VAW   = 19,
  parameter int LAW   = LRAM_AW
) (
  input  logic           gclk,
  input  logic           rstn,
  input  logic           hcomp,
  input  logic           vcomp,
  input  logic           vpstart,
  input  logic           vrtc,
  input  logic           lramsel,
  input  logic [7:0]     hvis,
  input  logic [VAW-1:0] base_adr,
  input  logic [VAW-1:0] stride,
  output logic           vr_req,
  output logic [VAW-1:0] vr_adr,
  input  logic           vr_ack,
  input  logic           vr_rvalid,
  input  logic [15:0]    vr_rdat,
  output logic           lw_en,
  output logic           lw_bank,
  output logic [LAW-1:0] lw_adr,
  output logic [15:0]    lw_dat,
  output logic           busy,
  output logic           underrun
);

  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int PW = LAW + 1;
  localparam logic [PW-1:0] PMAX = PW'(1) << LAW;

  fill_state_t    r_state;
  logic [VAW-1:0] r_row;
  logic [VAW-1:0] r_stride;
  logic [VAW-1:0] r_vr_adr;
  logic [PW-1:0]  r_pix;
  logic [PW-1:0]  r_npix;
  logic [BW-1:0]  r_beat;
  logic           r_wbank;
  logic           r_pend;
  logic           r_stop;
  logic           r_sup;
  logic           r_underrun;
  logic           r_vr_req;
  logic           r_lw_en;
  logic           r_lw_bank;
  logic [LAW-1:0] r_lw_adr;
  logic [15:0]    r_lw_dat;

  logic [10:0]    w_hpx;
  logic [PW-1:0]  w_npix;
  logic [PW-1:0]  w_npix_eff;
  logic [PW-1:0]  w_lead;
  logic [PW-1:0]  w_pix_nx;
  logic [VAW-1:0] w_row;
  logic           w_bank;
  logic           w_start;
  logic           w_busy;
  logic           w_bstart;
  logic           w_beat;
  logic           w_last;
  logic           w_done;
  logic           w_pend;
  logic           w_stop;
  logic           w_sup;
  logic           w_wr;

  // Visible width in pixels, clamped to one line-RAM bank.
  assign w_hpx  = {hvis, 3'b000};
  assign w_npix = ({21'd0, w_hpx} > 32'(PMAX)) ? PMAX : PW'(w_hpx);

  assign w_start  = hcomp & (vpstart | vrtc);
  assign w_busy   = r_state != FILL_IDLE;
  assign w_bstart = w_start & w_busy;

  assign w_row = !w_start ? r_row :
                 vpstart  ? base_adr :
                            r_row + r_stride;

  assign w_bank     = w_start ? lramsel : r_wbank;
  assign w_npix_eff = w_start ? w_npix : r_npix;

  assign w_beat   = (r_state == FILL_DATA) & vr_rvalid;
  assign w_last   = w_beat & (r_beat == BW'(BURST - 1));
  assign w_lead   = r_pix + PW'(r_beat);
  assign w_pix_nx = r_pix + PW'(BURST);
  assign w_done   = w_pix_nx >= r_npix;

  // A start during a fill abandons the current line; a later start
  // overrides an earlier pending one, and a frame end cancels both.
  assign w_pend = w_bstart | (r_pend & ~vcomp);
  assign w_stop = ~w_bstart & (r_stop | vcomp);
  assign w_sup  = w_bstart | r_sup | vcomp;
  assign w_wr   = w_beat & ~w_sup & (w_lead < r_npix);

  always_ff @(posedge gclk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= FILL_IDLE;
      r_row      <= '0;
      r_stride   <= '0;
      r_vr_adr   <= '0;
      r_pix      <= '0;
      r_npix     <= '0;
      r_beat     <= '0;
      r_wbank    <= 1'b0;
      r_pend     <= 1'b0;
      r_stop     <= 1'b0;
      r_sup      <= 1'b0;
      r_underrun <= 1'b0;
      r_vr_req   <= 1'b0;
      r_lw_en    <= 1'b0;
      r_lw_bank  <= 1'b0;
      r_lw_adr   <= '0;
      r_lw_dat   <= '0;
    end else begin
      r_row   <= w_row;
      r_wbank <= w_bank;
      r_npix  <= w_npix_eff;
      if (w_start && vpstart)
        r_stride <= stride;

      if (w_bstart)
        r_underrun <= 1'b1;
      else if (vcomp)
        r_underrun <= 1'b0;

      r_lw_en <= w_wr;
      if (w_beat) begin
        r_lw_bank <= r_wbank;
        r_lw_adr  <= w_lead[LAW-1:0];
        r_lw_dat  <= vr_rdat;
      end

      unique case (r_state)
        FILL_IDLE: begin
          r_pend <= 1'b0;
          r_stop <= 1'b0;
          r_sup  <= 1'b0;
          if (w_start && w_npix != '0) begin
            r_state  <= FILL_REQ;
            r_vr_req <= 1'b1;
            r_vr_adr <= w_row;
            r_pix    <= '0;
          end
        end
        FILL_REQ: begin
          r_pend <= w_pend;
          r_stop <= w_stop;
          r_sup  <= w_sup;
          if (vr_ack) begin
            r_state  <= FILL_DATA;
            r_vr_req <= 1'b0;
            r_beat   <= '0;
          end
        end
        FILL_DATA: begin
          r_pend <= w_pend;
          r_stop <= w_stop;
          r_sup  <= w_sup;
          if (w_beat)
            r_beat <= r_beat + BW'(1);
          if (w_last) begin
            if (w_pend && w_npix_eff != '0) begin
              r_state  <= FILL_REQ;
              r_vr_req <= 1'b1;
              r_vr_adr <= w_row;
              r_pix    <= '0;
              r_pend   <= 1'b0;
              r_stop   <= 1'b0;
              r_sup    <= 1'b0;
            end else if (w_pend || w_stop || w_done) begin
              r_state <= FILL_IDLE;
              r_pend  <= 1'b0;
              r_stop  <= 1'b0;
              r_sup   <= 1'b0;
            end else begin
              r_state  <= FILL_REQ;
              r_vr_req <= 1'b1;
              r_vr_adr <= r_row + VAW'(w_pix_nx);
              r_pix    <= w_pix_nx;
            end
          end
        end
        default: r_state <= FILL_IDLE;
      endcase
    end
  end

  assign vr_req   = r_vr_req;
  assign vr_adr   = r_vr_adr;
  assign lw_en    = r_lw_en;
  assign lw_bank  = r_lw_bank;
  assign lw_adr   = r_lw_adr;
  assign lw_dat   = r_lw_dat;
  assign busy     = w_busy;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_lram_fill_ctrl.sv
// Randomized scoreboard bench for lram_fill_ctrl with a VRAM responder
// and a line-level reference model.
module tb_lram_fill_ctrl;

  localparam int BURST = 8;
  localparam int VAW   = 19;
  localparam int LAW   = 10;

  logic           gclk = 1'b0;
  logic           rstn;
  logic           hcomp, vcomp, vpstart, vrtc, lramsel;
  logic [7:0]     hvis;
  logic [VAW-1:0] base_adr, stride;
  logic           vr_req;
  logic [VAW-1:0] vr_adr;
  logic           vr_ack, vr_rvalid;
  logic [15:0]    vr_rdat;
  logic           lw_en, lw_bank;
  logic [LAW-1:0] lw_adr;
  logic [15:0]    lw_dat;
  logic           busy, underrun;

  int n_chk = 0;
  int n_err = 0;
  int n_wr  = 0;

  logic [VAW-1:0] q_req[$];
  logic [26:0]    q_wr[$];
  logic [VAW-1:0] m_row, m_stride;

  bit ack_en    = 1'b1;
  bit beat_hold = 1'b0;
  bit resp_busy = 1'b0;

  always #5 gclk = ~gclk;

  lram_fill_ctrl #(.BURST(BURST), .VAW(VAW), .LAW(LAW)) dut (
    .gclk(gclk), .rstn(rstn), .hcomp(hcomp), .vcomp(vcomp),
    .vpstart(vpstart), .vrtc(vrtc), .lramsel(lramsel), .hvis(hvis),
    .base_adr(base_adr), .stride(stride), .vr_req(vr_req),
    .vr_adr(vr_adr), .vr_ack(vr_ack), .vr_rvalid(vr_rvalid),
    .vr_rdat(vr_rdat), .lw_en(lw_en), .lw_bank(lw_bank),
    .lw_adr(lw_adr), .lw_dat(lw_dat), .busy(busy), .underrun(underrun)
  );

  function automatic logic [15:0] vram(input logic [VAW-1:0] a);
    return a[15:0] ^ 16'h5A3C ^ {13'd0, a[18:16]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Reference: one start event fetches the line at the walked row address.
  task automatic model_start(input bit vp, input bit bank, input bit full);
    int np, nb;
    if (vp) begin
      m_row    = base_adr;
      m_stride = stride;
    end else begin
      m_row = m_row + m_stride;
    end
    np = int'(hvis) * 8;
    if (np > 1024) np = 1024;
    nb = (np + BURST - 1) / BURST;
    if (!full) begin
      if (nb > 0) q_req.push_back(m_row);
      return;
    end
    for (int k = 0; k < nb; k++)
      q_req.push_back(m_row + VAW'(k * BURST));
    for (int p = 0; p < np; p++)
      q_wr.push_back({bank, 10'(p), vram(m_row + VAW'(p))});
  endtask

  task automatic pulse(input bit hc, input bit vc, input bit vp,
                       input bit vt, input bit sel);
    hcomp = hc; vcomp = vc; vpstart = vp; vrtc = vt; lramsel = sel;
    @(posedge gclk); #1;
    hcomp = 1'b0; vcomp = 1'b0; vpstart = 1'b0;
  endtask

  task automatic start_line(input bit vp, input bit full);
    bit sel;
    sel = 1'($urandom);
    model_start(vp, sel, full);
    pulse(1'b1, 1'b0, vp, 1'b1, sel);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((busy || resp_busy) && n < 20000) begin
      @(posedge gclk); #1;
      n++;
    end
    if (n >= 20000) begin
      n_chk++; n_err++;
      $display("FAIL %s_timeout act=busy exp=idle", nm);
    end
    repeat (2) begin @(posedge gclk); #1; end
    chk({nm, "_req_left"}, 64'(q_req.size()), 64'd0);
    chk({nm, "_wr_left"}, 64'(q_wr.size()), 64'd0);
  endtask

  // VRAM responder: random ack delay, BURST beats with random gaps.
  initial begin
    logic [VAW-1:0] ra;
    vr_ack = 1'b0; vr_rvalid = 1'b0; vr_rdat = '0;
    forever begin
      @(posedge gclk); #1;
      vr_ack = 1'b0; vr_rvalid = 1'b0;
      if (vr_req && ack_en && $urandom_range(0, 2) == 0) begin
        resp_busy = 1'b1;
        ra = vr_adr;
        vr_ack = 1'b1;
        @(posedge gclk); #1;
        vr_ack = 1'b0;
        while (beat_hold) begin @(posedge gclk); #1; end
        for (int b = 0; b < BURST; b++) begin
          vr_rvalid = 1'b1;
          vr_rdat = vram(ra + VAW'(b));
          @(posedge gclk); #1;
          vr_rvalid = 1'b0;
          repeat ($urandom_range(0, 2)) begin @(posedge gclk); #1; end
        end
        resp_busy = 1'b0;
      end
    end
  end

  // Monitor: pops expected requests and line-RAM writes.
  always @(negedge gclk) begin
    if (rstn) begin
      if (vr_req && vr_ack) begin
        if (q_req.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_req act=%0h exp=none", vr_adr);
        end else begin
          chk("req_adr", 64'(vr_adr), 64'(q_req.pop_front()));
        end
      end
      if (lw_en) begin
        n_wr++;
        if (q_wr.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_write act=%0h exp=none",
                   {lw_bank, lw_adr, lw_dat});
        end else begin
          chk("write", 64'({lw_bank, lw_adr, lw_dat}),
              64'(q_wr.pop_front()));
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic seen;
    int w0;
    rstn = 1'b0; hcomp = 0; vcomp = 0; vpstart = 0; vrtc = 0;
    lramsel = 0; hvis = '0; base_adr = '0; stride = '0;
    repeat (3) @(posedge gclk);
    #1;
    chk("reset_outs", 64'({vr_req, vr_adr, lw_en, lw_bank, lw_adr,
                          lw_dat, busy, underrun}), 64'd0);
    rstn = 1'b1;
    @(posedge gclk); #1;

    // Basic line and row walk
    hvis = 8'd4; base_adr = 19'h100; stride = 19'h200;
    start_line(1'b1, 1'b1);
    wait_idle("line1");
    chk("line1_underrun", 64'(underrun), 64'd0);
    start_line(1'b0, 1'b1);
    wait_idle("line2");
    start_line(1'b0, 1'b1);
    wait_idle("line3");

    // Width clamp to one bank
    hvis = 8'd130;
    start_line(1'b0, 1'b1);
    wait_idle("wide");
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Start while the request is still unacknowledged
    hvis = 8'd4; base_adr = 19'h100; stride = 19'h200;
    ack_en = 1'b0;
    start_line(1'b1, 1'b0);
    repeat (3) begin @(posedge gclk); #1; end
    chk("hold_req", 64'(vr_req), 64'd1);
    start_line(1'b0, 1'b1);
    chk("ovr_underrun", 64'(underrun), 64'd1);
    chk("ovr_req_kept", 64'({vr_req, vr_adr}), 64'({1'b1, 19'h100}));
    ack_en = 1'b1;
    wait_idle("ovr");
    chk("underrun_sticky", 64'(underrun), 64'd1);
    pulse(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("vcomp_clr", 64'(underrun), 64'd0);

    // Frame end during a burst
    beat_hold = 1'b1;
    start_line(1'b1, 1'b0);
    for (int i = 0; i < 200; i++) begin
      @(posedge gclk); #2;
      if (resp_busy) break;
    end
    @(posedge gclk); #1;
    pulse(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("vcomp_busy", 64'(busy), 64'd1);
    beat_hold = 1'b0;
    wait_idle("vcdrain");
    chk("vcdrain_state", 64'({busy, underrun}), 64'd0);

    // No start outside the visible window, and empty width
    seen = 1'b0;
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (5) begin @(posedge gclk); #1; seen |= vr_req | busy; end
    chk("novis_idle", 64'(seen), 64'd0);
    hvis = 8'd0;
    start_line(1'b1, 1'b1);
    chk("hvis0_idle", 64'({busy, vr_req}), 64'd0);
    wait_idle("hvis0");

    // Asynchronous reset in the middle of a burst
    hvis = 8'd4;
    w0 = n_wr;
    start_line(1'b1, 1'b1);
    for (int i = 0; i < 200; i++) begin
      @(posedge gclk); #1;
      if (n_wr > w0) break;
    end
    #3 rstn = 1'b0;
    #1;
    chk("async_rst", 64'({vr_req, vr_adr, lw_en, lw_bank, lw_adr,
                         lw_dat, busy, underrun}), 64'd0);
    q_req.delete();
    q_wr.delete();
    @(posedge gclk); #1;
    rstn = 1'b1;
    wait_idle("rst");

    // Randomized frames
    for (int f = 0; f < 5; f++) begin
      base_adr = VAW'($urandom);
      stride   = VAW'($urandom);
      for (int l = 0; l < 4; l++) begin
        hvis = 8'($urandom_range(0, 20));
        if ($urandom_range(0, 3) == 0)
          pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'($urandom));
        start_line(l == 0, 1'b1);
        wait_idle("rnd");
        chk("rnd_underrun", 64'(underrun), 64'd0);
        repeat ($urandom_range(0, 4)) begin @(posedge gclk); #1; end
      end
      pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
